// File: rtl/path_pkg.sv
// Shared definitions for the path job controller: FSM encoding and default
// data-memory locations of the start/end node words.
package path_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_START,
        LOAD_END,
        RUN,
        CAPTURE,
        STREAM,
        ABORT
    } state_t;

    localparam int          PATH_MAX_NODES = 13;
    localparam logic [31:0] PATH_START_ADR = 32'h0200_0000;
    localparam logic [31:0] PATH_END_ADR   = 32'h0200_0004;

endpackage

// File: rtl/node_streamer.sv
// Holds a captured path and serializes it one node per valid/ready transfer,
// flagging the final node with last.
module node_streamer
    import path_pkg::*;
#(
    parameter int MAX_NODES = PATH_MAX_NODES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cap_i,
    input  logic                   go_i,
    input  logic [MAX_NODES*8-1:0] path_i,
    input  logic [7:0]             len_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [7:0]             data_o,
    output logic                   last_o,
    output logic                   done_o
);
    localparam int PTR_W = $clog2(MAX_NODES);

    logic [MAX_NODES-1:0][7:0] arr_q;
    logic [7:0]                len_q;
    logic [PTR_W-1:0]          ptr_q;
    logic                      active_q;

    // The path is latched even when the length is rejected; go_i decides
    // whether streaming actually starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            arr_q    <= '0;
            len_q    <= '0;
            ptr_q    <= '0;
            active_q <= 1'b0;
        end else if (cap_i) begin
            arr_q    <= path_i;
            len_q    <= len_i;
            ptr_q    <= '0;
            active_q <= go_i;
        end else if (valid_o && ready_i) begin
            if (last_o) active_q <= 1'b0;
            else        ptr_q    <= ptr_q + PTR_W'(1);
        end
    end

    assign valid_o = active_q;
    assign data_o  = arr_q[ptr_q];
    assign last_o  = active_q && (8'(ptr_q) == len_q - 8'd1);
    assign done_o  = valid_o && ready_i && last_o;

endmodule

// File: rtl/path_job_ctrl.sv
// Sequences one path-planning job: preloads start/end nodes into CPU data
// memory, runs the CPU with a timeout, then streams the resulting path out.
module path_job_ctrl
    import path_pkg::*;
#(
    parameter logic [31:0] START_ADR      = PATH_START_ADR,
    parameter logic [31:0] END_ADR        = PATH_END_ADR,
    parameter int          TIMEOUT_CYCLES = 2_000_000,
    parameter int          MAX_NODES      = PATH_MAX_NODES
) (
    input  logic                   adc_sck,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             start_node,
    input  logic [7:0]             end_node,
    output logic                   cpu_rst,
    output logic                   Ext_MemWrite,
    output logic [31:0]            Ext_WriteData,
    output logic [31:0]            Ext_DataAdr,
    input  logic                   cpu_done,
    output logic                   cpu_reset,
    input  logic [MAX_NODES*8-1:0] path_flat,
    input  logic [7:0]             index,
    output logic                   node_valid,
    input  logic                   node_ready,
    output logic [7:0]             node_data,
    output logic                   node_last,
    output logic                   busy,
    output logic                   error
);
    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic [7:0]  start_q, start_d, end_q, end_d;
    logic        idx_ok, strm_done;

    assign idx_ok = (index != 8'd0) && (index <= 8'(MAX_NODES));

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        case (state_q)
            IDLE: if (req_valid) begin
                start_d = start_node;
                end_d   = end_node;
                state_d = LOAD_START;
            end
            LOAD_START: state_d = LOAD_END;
            LOAD_END:   state_d = RUN;
            // A done flag left over from the previous job can still be high
            // for the first two cycles after the core leaves reset.
            RUN: begin
                if (cpu_done && cnt_q >= 32'd2)
                    state_d = CAPTURE;
                else if (cnt_q == 32'(TIMEOUT_CYCLES - 1))
                    state_d = ABORT;
            end
            CAPTURE: state_d = idx_ok ? STREAM : ABORT;
            STREAM:  if (strm_done) state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge adc_sck) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            start_q       <= '0;
            end_q         <= '0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            cpu_rst       <= 1'b1;
            cpu_reset     <= 1'b0;
            error         <= 1'b0;
            Ext_MemWrite  <= 1'b0;
            Ext_DataAdr   <= '0;
            Ext_WriteData <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= (state_q == RUN) ? cnt_q + 32'd1 : 32'd0;
            start_q      <= start_d;
            end_q        <= end_d;
            req_ready    <= (state_d == IDLE);
            busy         <= (state_d != IDLE);
            cpu_rst      <= (state_d != RUN);
            cpu_reset    <= (state_d == LOAD_START);
            error        <= (state_d == ABORT);
            Ext_MemWrite <= (state_d == LOAD_START) || (state_d == LOAD_END);
            case (state_d)
                LOAD_START: begin
                    Ext_DataAdr   <= START_ADR;
                    Ext_WriteData <= {24'b0, start_d};
                end
                LOAD_END: begin
                    Ext_DataAdr   <= END_ADR;
                    Ext_WriteData <= {24'b0, end_d};
                end
                default: begin
                    Ext_DataAdr   <= '0;
                    Ext_WriteData <= '0;
                end
            endcase
        end
    end

    node_streamer #(.MAX_NODES(MAX_NODES)) u_streamer (
        .clk     (adc_sck),
        .reset   (reset),
        .cap_i   (state_q == CAPTURE),
        .go_i    (idx_ok),
        .path_i  (path_flat),
        .len_i   (index),
        .ready_i (node_ready),
        .valid_o (node_valid),
        .data_o  (node_data),
        .last_o  (node_last),
        .done_o  (strm_done)
    );

endmodule
